// File: rtl/gray_codec_pkg.sv
// rtl/gray_codec_pkg.sv - shared types and code conversion helpers for gray_bin_codec
// Contents: mode typedef, GRAY_MAX_W, gray2bin, bin2gray, popcount.
// All helpers take GRAY_MAX_W-wide words. Callers zero-extend narrower words,
// which leaves the low bits of the result correct for any width up to GRAY_MAX_W.
package gray_codec_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } mode_e;

  // Each binary bit is the XOR of every Gray bit at or above it. Zero upper
  // bits add nothing to that XOR, so narrow words convert correctly.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    logic [GRAY_MAX_W-1:0] g;
    g = '0;
    g[GRAY_MAX_W-1] = b[GRAY_MAX_W-1];
    for (int i = 0; i < GRAY_MAX_W - 1; i++) begin
      g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_codec_slot.sv
// rtl/gray_codec_slot.sv - one pipeline slot of gray_bin_codec
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   up_valid, up_data    beat offered by the upstream slot (or the input)
//   down_ready           ready of the downstream slot (or the consumer)
//   valid, data          registered slot contents
//   ready                slot can load this cycle: empty, or draining downstream
module gray_codec_slot #(
  parameter int PW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [PW-1:0] up_data,
  input  logic          down_ready,
  output logic          valid,
  output logic [PW-1:0] data,
  output logic          ready
);

  assign ready = ~valid | down_ready;

  // Loading the upstream valid even when it is low lets bubbles collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      data  <= up_data;
    end
  end

endmodule

// File: rtl/gray_bin_codec.sv
// rtl/gray_bin_codec.sv - pipelined Gray/binary converter with per-beat direction
// Optional feature macro: GRAY_CODEC_ADJ_CHECK_EN (adds out_adj_err and Gray adjacency tracking).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid, in_ready, in_data     input stream
//   in_mode                         0 = Gray->binary, 1 = binary->Gray
//   out_valid, out_ready, out_data  output stream, STAGES cycles after accept
//   out_mode                        in_mode of the beat being presented
//   out_adj_err                     (macro only) Gray input not adjacent to previous Gray input
module gray_bin_codec
  import gray_codec_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  ,
  output logic             out_adj_err
`endif
);

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  logic [GRAY_MAX_W-1:0] in_ext;
  logic [WIDTH-1:0]      conv;
  logic [PW-1:0]         in_pl;
  logic [PW-1:0]         last_pl;

  assign in_ext = GRAY_MAX_W'(in_data);
  assign conv   = (mode_e'(in_mode) == MODE_B2G) ? WIDTH'(bin2gray(in_ext))
                                                 : WIDTH'(gray2bin(in_ext));

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic [WIDTH-1:0] last_gray;
  logic             seen;
  logic             accept;
  logic             is_gray;
  logic [5:0]       dist;
  logic             adj_err_in;

  assign accept     = in_valid & in_ready;
  assign is_gray    = (mode_e'(in_mode) == MODE_G2B);
  assign dist       = popcount(GRAY_MAX_W'(in_data ^ last_gray));
  assign adj_err_in = is_gray & seen & (dist != 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gray <= '0;
      seen      <= 1'b0;
    end else if (accept && is_gray) begin
      last_gray <= in_data;
      seen      <= 1'b1;
    end
  end

  assign in_pl       = {adj_err_in, in_mode, conv};
  assign out_adj_err = last_pl[WIDTH+1];
`else
  assign in_pl = {in_mode, conv};
`endif

  // Each generate block owns its own valid/data/ready nets so the ready chain
  // is a set of distinct signals rather than one self-referencing vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic          vld;
    logic [PW-1:0] dat;
    logic          rdy;
    logic          up_vld;
    logic [PW-1:0] up_dat;
    logic          dn_rdy;

    if (i == 0) begin : g_first
      assign up_vld = in_valid;
      assign up_dat = in_pl;
    end else begin : g_mid
      assign up_vld = g_slot[i-1].vld;
      assign up_dat = g_slot[i-1].dat;
    end

    if (i == STAGES - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_inner
      assign dn_rdy = g_slot[i+1].rdy;
    end

    gray_codec_slot #(.PW(PW)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_vld),
      .up_data    (up_dat),
      .down_ready (dn_rdy),
      .valid      (vld),
      .data       (dat),
      .ready      (rdy)
    );
  end

  assign in_ready  = g_slot[0].rdy;
  assign out_valid = g_slot[STAGES-1].vld;
  assign last_pl   = g_slot[STAGES-1].dat;
  assign out_data  = last_pl[WIDTH-1:0];
  assign out_mode  = last_pl[WIDTH];

endmodule

// File: tb/tb_gray_bin_codec.sv
// tb/tb_gray_bin_codec.sv - directed self-checking bench for gray_bin_codec
module tb_gray_bin_codec;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_mode;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic         out_adj_err;
`endif

  int           vectors = 0;
  int           miscompares = 0;
  int           total_emits = 0;
  exp_t         exp_q[$];
  logic [W-1:0] cur_exp = '0;
  logic         cur_err = 1'b0;
  bit           chk_err = 1'b0;
  bit           acc_f;
  bit           emit_f;

  gray_bin_codec #(.WIDTH(W), .STAGES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_mode    (out_mode)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    ,
    .out_adj_err (out_adj_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [W-1:0] d, input logic m, input logic [W-1:0] e, input logic er);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    cur_exp  = e;
    cur_err  = er;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called at the falling edge: records handshakes of the coming rising edge,
  // scoreboards the emitted beat, then moves to just after that rising edge.
  task automatic handshake(output bit acc, output bit emit);
    exp_t x;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (emit) begin
      total_emits++;
      chk("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(x.data));
        chk("out_mode", 32'(out_mode), 32'(x.mode));
`ifdef GRAY_CODEC_ADJ_CHECK_EN
        if (chk_err) chk("out_adj_err", 32'(out_adj_err), 32'(x.err));
`endif
      end
    end
    if (acc) exp_q.push_back('{cur_exp, in_mode, cur_err});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic m, input logic [W-1:0] e, input logic er);
    drive(d, m, e, er);
    @(negedge clk);
    handshake(acc_f, emit_f);
    chk("send_accepted", 32'(acc_f), 32'd1);
  endtask

  task automatic run(input int n);
    idle();
    repeat (n) begin
      @(negedge clk);
      handshake(acc_f, emit_f);
    end
  endtask

  initial begin
    logic [W-1:0] bp_exp [8];
    logic [W-1:0] d;
    logic         m;
    int           idx;
    int           base;
    int           first;
    int           last;

    bp_exp = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h07, 8'h06, 8'h04, 8'h05};

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    chk("rst_out_adj_err", 32'(out_adj_err), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic Gray->binary and latency of exactly STAGES cycles
    drive(8'h07, 1'b0, 8'h05, 1'b0);
    @(negedge clk);
    handshake(acc_f, emit_f);
    chk("first_accept", 32'(acc_f), 32'd1);
    chk("lat_cyc1_out_valid", 32'(out_valid), 32'd0);
    send(8'h0F, 1'b0, 8'h0A, 1'b0);
    chk("lat_cyc2_out_valid", 32'(out_valid), 32'd1);
    chk("g2b_0111", 32'(out_data), 32'h05);
    send(8'h00, 1'b0, 8'h00, 1'b0);
    run(4);

    // Wide values and interleaved modes
    send(8'h80, 1'b1, 8'hC0, 1'b0);
    send(8'h80, 1'b0, 8'hFF, 1'b0);
    send(8'h05, 1'b1, 8'h07, 1'b0);
    send(8'h05, 1'b0, 8'h06, 1'b0);
    send(8'hFF, 1'b1, 8'h80, 1'b0);
    send(8'h01, 1'b0, 8'h01, 1'b0);
    send(8'h3C, 1'b1, 8'h22, 1'b0);
    send(8'hC0, 1'b0, 8'h80, 1'b0);
    run(4);

    // Backpressure: out_ready low for cycles 3..6
    idx  = 0;
    base = total_emits;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 8) drive(W'(idx), 1'b0, bp_exp[idx], 1'b0);
      else idle();
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_data", 32'(out_data), 32'h01);
      end
      handshake(acc_f, emit_f);
      if (acc_f) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd8);
    chk("bp_all_emitted", 32'(total_emits - base), 32'd8);
    out_ready = 1'b1;

    // Sustained throughput
    base  = total_emits;
    first = -1;
    last  = -1;
    for (int k = 0; k < 262; k++) begin
      if (k < 256) begin
        d = W'($urandom);
        m = 1'($urandom);
        drive(d, m, m ? m_b2g(d) : m_g2b(d), 1'b0);
      end else begin
        idle();
      end
      @(negedge clk);
      handshake(acc_f, emit_f);
      if (emit_f) begin
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("tp_count", 32'(total_emits - base), 32'd256);
    chk("tp_first_latency", 32'(first), 32'd2);
    chk("tp_consecutive", 32'(last - first), 32'd255);

    // Reset with two beats in flight
    send(8'h11, 1'b1, 8'h19, 1'b0);
    send(8'h22, 1'b0, 8'h3C, 1'b0);
    idle();
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = total_emits;
    run(4);
    chk("no_stale_beat", 32'(total_emits - base), 32'd0);
    send(8'h55, 1'b1, 8'h7F, 1'b0);
    run(3);
    chk("post_reset_emit", 32'(total_emits - base), 32'd1);

`ifdef GRAY_CODEC_ADJ_CHECK_EN
    // Adjacency check; the mode-1 beat must not disturb the tracking
    chk_err = 1'b1;
    send(8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h01, 1'b0, 8'h01, 1'b0);
    send(8'h03, 1'b0, 8'h02, 1'b0);
    send(8'h55, 1'b1, 8'h7F, 1'b0);
    send(8'h00, 1'b0, 8'h00, 1'b1);
    run(4);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_bin_codec.md
# gray_bin_codec

Pipelined, parametrised Gray/binary code converter with a valid/ready stream interface. Each accepted beat carries its own direction bit, so Gray-to-binary and binary-to-Gray conversions can be mixed freely beat by beat. The block sits between Gray-coded sources (counters, encoders, CDC pointers) and binary consumers, or the reverse. It replaces fixed-width 4-bit combinational converters.

## Interface
- `WIDTH`, default 8: data width in bits; legal range 2..32.
- `STAGES`, default 2: number of pipeline register slots, which is also the latency; legal range 1..4.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: an input beat is present.
- `in_ready` output, 1 bit: the block can accept a beat.
- `in_data` input, WIDTH bits: code word to convert.
- `in_mode` input, 1 bit: direction; 0 = Gray→binary, 1 = binary→Gray.
- `out_valid` output, 1 bit: an output beat is present.
- `out_ready` input, 1 bit: the consumer accepts the output beat.
- `out_data` output, WIDTH bits: the converted word.
- `out_mode` output, 1 bit: `in_mode` of the beat, carried alongside it.
- `out_adj_err` output, 1 bit: adjacency error flag; exists only under `GRAY_CODEC_ADJ_CHECK_EN`.

## Operation
- **Transfer rule:** a beat transfers on a rising edge where valid and ready are both high, on either port.
- **Conversion:** done combinationally in front of slot 0 and captured into slot 0; slots 1..STAGES-1 are plain delay.
  - Gray→binary: `b[W-1]=g[W-1]`; `b[i]=b[i+1]^g[i]`.
  - Binary→Gray: `g = b ^ (b>>1)`.
  - Both are lossless and width-preserving; there is no overflow case.
- **Slot state:** each slot holds valid, data, mode (and the error bit when the check is enabled).
- **Ready chain:** `ready[i] = ~valid[i] | ready[i+1]`, with `ready[STAGES] = out_ready`. `in_ready = ready[0]`. The ready path is combinational through the slots.
- **Slot advance:** slot i loads from slot i-1 (or from the input, for slot 0) when `ready[i]` is high. Its valid bit takes the upstream valid, so bubbles collapse.
- **Output:** `out_valid`, `out_data`, `out_mode` come from the last slot.
- **Stall:** while `out_valid=1` and `out_ready=0`, the output and all full slots hold stable.
- **Ordering:** beats never reorder, drop or duplicate.
- **Reset values:** on `rst_n=0`, all slot valid bits are 0, all data/mode bits are 0, `out_valid=0`, `out_adj_err=0`, and `in_ready=1` once reset releases.
- **Reset mid-operation:** in-flight beats are discarded. There is no partial-beat state.

## Timing
- **Latency:** exactly STAGES cycles from an input handshake to `out_valid`, with no backpressure.
- **Throughput:** 1 beat per cycle with `out_ready` held high, sustained indefinitely.
- **Full pipeline:** when every slot is full and `out_ready=0`, `in_ready=0` in the same cycle.
- **Simultaneous events:** `out_ready=1` while the pipeline is full gives `in_ready=1` in that same cycle. The accept and the emit occur on the same edge.
- **Reset release:** the first accept can occur on the first rising edge after `rst_n` rises.

## Configuration
- **`GRAY_CODEC_ADJ_CHECK_EN` defined:**
  - The block tracks the last accepted mode-0 (Gray) input word and a `seen` flag, both reset to 0.
  - Each accepted mode-0 beat with `seen=1` whose Hamming distance from the stored word is not exactly 1 gets its error bit set.
  - The error bit travels with the beat and appears as `out_adj_err`, aligned with `out_valid`.
  - Mode-1 beats never flag an error and do not update the stored word.
- **Macro undefined:** the `out_adj_err` port, the tracking registers and the per-slot error bit are all absent. Conversion behaviour is identical either way.

## Structure
- **Package `gray_codec_pkg`** contains:
  - the mode typedef (`MODE_G2B=1'b0`, `MODE_B2G=1'b1`);
  - the functions `gray2bin` and `bin2gray`, written for a generic width via a loop bounded by a package constant `GRAY_MAX_W=32`;
  - the `popcount` function used by the adjacency check.
- **Sub-module `gray_codec_slot`:** one pipeline slot (valid/data/mode/err register plus its ready term). It is instantiated STAGES times in a generate loop.

## Test plan
- **Basic Gray→binary:** WIDTH=4, STAGES=2, `out_ready=1`; mode 0, `in_data=0111` → after 2 cycles `out_data=0101`. Likewise `1111` → `1010`, and `0000` → `0000`.
- **Wide binary→Gray:** WIDTH=8; mode 1 with `8'h80` → `8'hC0`; mode 0 with `8'h80` → `8'hFF`. Then interleave the two modes every beat and check that `out_mode` tracks each beat.
- **Backpressure:** WIDTH=4, STAGES=2; stream 0..7 with `out_ready` low for cycles 3–6.
  - `in_ready` must drop after 2 beats are stored.
  - The output must hold stable while stalled.
  - All 8 results must arrive in order with no loss.
- **Sustained throughput:** 256 back-to-back beats with `out_ready=1` → 256 outputs on 256 consecutive cycles, each equal to the reference model.
- **Reset mid-stream:** assert `rst_n=0` with 2 beats in flight → `out_valid=0` immediately (asynchronously), and no stale beat appears after release.
- **Adjacency check (macro defined):** Gray inputs `0000`, `0001`, `0011`, `0000`.
  - `out_adj_err` must be 0, 0, 0, 1.
  - A mode-1 beat inserted between them leaves the flags unchanged.
